// File: rtl/operand_fetch.sv
// Operand fetch: register file, busy scoreboard and a registered valid/ready
// output toward execute. Define OPFETCH_BYPASS_EN to forward same-cycle writeback data.
module operand_fetch #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_regwrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   out_rd,
  output logic            out_regwrite,
  input  logic            wb_regwrite,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic            wb_we;
  logic            accept;
  logic            hazard;
  logic            rs1_busy, rs2_busy, rd_busy;
  logic            rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] rs1_val, rs2_val;

  // Index names a real, writable register (not x0, not beyond the file).
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return (idx != '0) && (int'(idx) < NREG);
  endfunction

  assign wb_we    = wb_regwrite && idx_ok(wb_rd);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rs1_val  = '0;
    rs2_val  = '0;
    rs1_busy = idx_ok(in_rs1) && busy[in_rs1];
    rs2_busy = idx_ok(in_rs2) && busy[in_rs2];
    rd_busy  = in_regwrite && idx_ok(in_rd) && busy[in_rd];
`ifdef OPFETCH_BYPASS_EN
    rs1_fwd  = wb_we && (wb_rd == in_rs1);
    rs2_fwd  = wb_we && (wb_rd == in_rs2);
`else
    rs1_fwd  = 1'b0;
    rs2_fwd  = 1'b0;
`endif
    // WAW is never forgiven by a same-cycle writeback.
    hazard = (rs1_busy && !rs1_fwd) || (rs2_busy && !rs2_fwd) || rd_busy;

    if (rs1_fwd)             rs1_val = wb_data;
    else if (idx_ok(in_rs1)) rs1_val = regs[in_rs1];
    if (rs2_fwd)             rs2_val = wb_data;
    else if (idx_ok(in_rs2)) rs2_val = regs[in_rs2];
  end

  // Clear first so a same-index set in the same cycle wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_we) busy_nxt[wb_rd] = 1'b0;
    if (accept && in_regwrite && idx_ok(in_rd)) busy_nxt[in_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is architecturally cleared on reset, so it is
      // built from flops rather than an unresettable RAM macro.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs1_data <= rs1_val;
      out_rs2_data <= rs2_val;
      out_rd       <= in_rd;
      out_regwrite <= in_regwrite;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; follows OPFETCH_BYPASS_EN for the RAW case.
module tb_operand_fetch;

  localparam int NREG = 32;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd;
  logic            in_regwrite;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data;
  logic [AW-1:0]   out_rd;
  logic            out_regwrite;
  logic            wb_regwrite;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  operand_fetch #(.NREG(NREG), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rw);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_regwrite = rw;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_regwrite = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    #1;
  endtask

  task automatic wb(input logic en, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    wb_regwrite = en; wb_rd = rd; wb_data = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_regwrite = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rs1_data", out_rs1_data, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Reset then read.
    issue(5'd3, 5'd0, 5'd0, 1'b0);
    check("rr_in_ready", 32'(in_ready), 32'd1);
    tick(); idle();
    check("rr_out_valid", 32'(out_valid), 32'd1);
    check("rr_rs1", out_rs1_data, 32'd0);
    check("rr_rs2", out_rs2_data, 32'd0);

    // Write then read with one-cycle latency.
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    tick(); wb(1'b0, 5'd0, 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    tick();
    issue(5'd5, 5'd0, 5'd2, 1'b0);
    tick(); idle();
    check("wr_out_valid", 32'(out_valid), 32'd1);
    check("wr_rs1", out_rs1_data, 32'hDEADBEEF);
    check("wr_rd", 32'(out_rd), 32'd2);

    // RAW stall on x7.
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    check("raw_first_ready", 32'(in_ready), 32'd1);
    tick();
    issue(5'd0, 5'd7, 5'd1, 1'b0);
    check("raw_stall0", 32'(in_ready), 32'd0);
    tick();
    check("raw_stall1", 32'(in_ready), 32'd0);
    check("raw_bubble", 32'(out_valid), 32'd0);
    wb(1'b1, 5'd7, 32'h1234);
`ifdef OPFETCH_BYPASS_EN
    check("raw_byp_ready", 32'(in_ready), 32'd1);
    tick(); wb(1'b0, 5'd0, 32'd0); idle();
`else
    check("raw_nobyp_ready", 32'(in_ready), 32'd0);
    tick(); wb(1'b0, 5'd0, 32'd0);
    check("raw_nobyp_ready2", 32'(in_ready), 32'd1);
    tick(); idle();
`endif
    check("raw_out_valid", 32'(out_valid), 32'd1);
    check("raw_rs2", out_rs2_data, 32'h1234);
    check("raw_rd", 32'(out_rd), 32'd1);

    // WAW on x4.
    issue(5'd0, 5'd0, 5'd4, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd4, 1'b1);
    check("waw_stall0", 32'(in_ready), 32'd0);
    tick();
    wb(1'b1, 5'd4, 32'h44);
    check("waw_wb_cycle", 32'(in_ready), 32'd0);
    tick(); wb(1'b0, 5'd0, 32'd0);
    check("waw_release", 32'(in_ready), 32'd1);
    tick(); idle();
    check("waw_out_rd", 32'(out_rd), 32'd4);
    check("waw_out_regwrite", 32'(out_regwrite), 32'd1);
    wb(1'b1, 5'd4, 32'h45);
    tick(); wb(1'b0, 5'd0, 32'd0);

    // x0 as destination never stalls; writes to x0 are dropped.
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    check("x0_no_stall", 32'(in_ready), 32'd1);
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    tick(); wb(1'b0, 5'd0, 32'd0);
    issue(5'd0, 5'd0, 5'd0, 1'b0);
    tick(); idle();
    check("x0_reads_zero_rs1", out_rs1_data, 32'd0);
    check("x0_reads_zero_rs2", out_rs2_data, 32'd0);
    tick();

    // Backpressure: three stalled cycles, then no bubble on release.
    out_ready = 1'b0;
    issue(5'd5, 5'd0, 5'd3, 1'b0);
    check("bp_first_ready", 32'(in_ready), 32'd1);
    tick();
    issue(5'd0, 5'd5, 5'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_rs1_hold", out_rs1_data, 32'hDEADBEEF);
      check("bp_rd_hold", 32'(out_rd), 32'd3);
      tick();
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick(); idle();
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_rs1", out_rs1_data, 32'd0);
    check("bp_next_rs2", out_rs2_data, 32'hDEADBEEF);
    check("bp_next_rd", 32'(out_rd), 32'd6);

    // Reset while a RAW stall on x9 is pending.
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    issue(5'd9, 5'd5, 5'd0, 1'b0);
    check("ms_stall", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("ms_rst_out_valid", 32'(out_valid), 32'd0);
    check("ms_rst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    #1;
    check("ms_ready_after", 32'(in_ready), 32'd1);
    tick(); idle();
    check("ms_out_valid", 32'(out_valid), 32'd1);
    check("ms_rs1_zero", out_rs1_data, 32'd0);
    check("ms_rs2_cleared", out_rs2_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
